// File: rtl/pulse_delay_line.sv
// Multi-channel, runtime-programmable pulse/level delay line with optional
// rising-edge output and a valid flag that masks the output while the pipeline refills.
module pulse_delay_line #(
  parameter int DATA_BITS = 1,
  parameter int MAX_DELAY = 8,
  parameter int DELAY_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DELAY_W-1:0]   delay_cfg,
  input  logic                 edge_mode,
  input  logic [DATA_BITS-1:0] pulse_src,
  output logic [DATA_BITS-1:0] pulse_des,
  output logic                 des_valid,
  output logic                 cfg_err
);

  // pulse_des is itself the last register, so the shift chain needs one stage fewer.
  localparam int STAGES = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;
  localparam logic [DELAY_W-1:0] LAST_TAP = DELAY_W'(MAX_DELAY - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t               state_q;
  logic [DELAY_W-1:0]   cnt_q;
  logic [DELAY_W-1:0]   cfg_sh_q;
  logic                 mode_sh_q;
  logic [DATA_BITS-1:0] stage_q [STAGES];
  logic [DATA_BITS-1:0] prev_tap_q;
  logic [DATA_BITS-1:0] pulse_des_q;
  logic                 des_valid_q;
  logic                 cfg_err_q;

  logic                 cfg_over;
  logic [DELAY_W-1:0]   eff;
  logic                 restart;
  logic [DATA_BITS-1:0] tap_line [MAX_DELAY];
  logic [DATA_BITS-1:0] tap;
  logic [DATA_BITS-1:0] des_d;

  assign cfg_over = ({1'b0, delay_cfg} >= (DELAY_W + 1)'(MAX_DELAY));
  assign eff      = cfg_over ? LAST_TAP : delay_cfg;
  assign restart  = clear || (delay_cfg != cfg_sh_q) || (edge_mode != mode_sh_q);

  // tap_line[k] holds the input sampled k edges ago; index eff gives latency eff+1.
  assign tap_line[0] = pulse_src;
  for (genvar gi = 1; gi < MAX_DELAY; gi++) begin : g_tap
    assign tap_line[gi] = stage_q[gi-1];
  end

  assign tap   = tap_line[eff];
  assign des_d = edge_mode ? (tap & ~prev_tap_q) : tap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
      prev_tap_q  <= '0;
      pulse_des_q <= '0;
      des_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
      cfg_sh_q    <= '0;
      mode_sh_q   <= 1'b0;
      state_q     <= FILL;
    end else begin
      if (clear) begin
        for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        prev_tap_q <= '0;
      end else begin
        stage_q[0] <= pulse_src;
        for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
        prev_tap_q <= tap;
      end
      cfg_sh_q  <= delay_cfg;
      mode_sh_q <= edge_mode;
      cfg_err_q <= cfg_over;

      if (restart) begin
        state_q     <= FILL;
        cnt_q       <= '0;
        des_valid_q <= 1'b0;
        pulse_des_q <= '0;
      end else begin
        case (state_q)
          FILL: begin
            if (cnt_q == eff) begin
              state_q     <= RUN;
              des_valid_q <= 1'b1;
              pulse_des_q <= des_d;
            end else begin
              cnt_q       <= cnt_q + DELAY_W'(1);
              pulse_des_q <= '0;
            end
          end
          RUN: begin
            pulse_des_q <= des_d;
          end
          default: begin
            state_q     <= FILL;
            cnt_q       <= '0;
            des_valid_q <= 1'b0;
            pulse_des_q <= '0;
          end
        endcase
      end
    end
  end

  assign pulse_des = pulse_des_q;
  assign des_valid = des_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule
